mem_port_arbiter: RTL

Sequencing controller that shares one single-ported unified memory between the instruction-fetch stage and the data (load/store) stage of the MIPS core. It accepts one request per side, grants one access at a time, and drives the memory with registered enable, write, address and write-data. It returns read data to the granted requester with a one-cycle ready pulse. The block sits between the PC/fetch logic, the memory stage and a synchronous-read memory. Fixed-latency memory is assumed by construction.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports and memory port of the unified-memory arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              gnt_data;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_data
    );

    // Requesters plus memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [RUN_W-1:0]  data_run;
    logic              we_q;

    logic              want_data;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // Grant selection: data wins a tie until it has run MAX_DATA_RUN times in a row past a waiting fetch
    always_comb begin
        want_data   = bus.d_req && (!bus.if_req || (data_run != RUN_MAX));
        grant_addr  = want_data ? bus.d_addr : bus.if_addr;
        grant_wdata = want_data ? bus.d_wdata : bus.mem_wdata;
    end

    // Access sequencer; every output is a register so reset clears them all at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            data_run      <= '0;
            we_q          <= 1'b0;
            bus.if_ready  <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
            bus.gnt_data  <= 1'b0;
        end else begin
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state         <= ISSUE;
                        bus.busy      <= 1'b1;
                        bus.gnt_data  <= want_data;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_wdata <= grant_wdata;
                        we_q          <= want_data && bus.d_we;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= want_data && bus.d_we;
                        if (want_data && bus.if_req)
                            data_run <= (data_run == RUN_MAX) ? data_run : data_run + RUN_W'(1);
                        else
                            data_run <= '0;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!bus.gnt_data)
                            bus.if_rdata <= bus.mem_rdata;
                        else if (!we_q)
                            bus.d_rdata <= bus.mem_rdata;
                        bus.if_ready <= !bus.gnt_data;
                        bus.d_ready  <= bus.gnt_data;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
